hilo_mdu_ctrl: RTL and testbench
================================

# hilo_mdu_ctrl

Multiply/divide sequencer that owns every write into the HI/LO register pair. It sits in the ID/EX region beside the HI/LO register and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the pipeline. It runs a single-cycle-issue multiply and a 32-iteration restoring divider, then drives the HI/LO write-enable and data ports. It raises `busy` so the pipeline stalls while an operation is in flight.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op_valid` in 1: an operation is presented this cycle.
- `op` in 3: operation code. 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. 110 and 111 are no-ops and are ignored.
- `rs_data` in 32: multiplicand, dividend, or MTHI/MTLO source.
- `rt_data` in 32: multiplier or divisor.
- `flush` in 1: exception flush. Aborts any in-flight operation.
- `busy` out 1: an operation is in flight; upstream must hold.
- `whi` out 1: HI write enable (one-cycle pulse).
- `wlo` out 1: LO write enable (one-cycle pulse).
- `hi_wdata` out 32: data for HI.
- `lo_wdata` out 32: data for LO.

## Operation
- **States:** IDLE, MUL, DIV, FIX.
  - Reset puts the block in IDLE with `whi`=`wlo`=0, `hi_wdata`=`lo_wdata`=0, and the internal counter and accumulators cleared.
- **Acceptance:** an operation is accepted only in IDLE, with `op_valid`=1 and `flush`=0.
  - `op_valid` outside IDLE is ignored; there is no queueing.
- **MTHI / MTLO:** state stays IDLE. The next edge registers `whi` (or `wlo`)=1 and `hi_wdata` (or `lo_wdata`)=`rs_data`.
- **MULT / MULTU:** IDLE→MUL. Operands are captured, with a sign-extension mode for MULT and zero-extension for MULTU.
  - In MUL, the 64-bit product is computed. HI gets bits [63:32] and LO gets [31:0]; `whi`=`wlo`=1 are registered; state returns to IDLE.
- **DIV / DIVU, divisor ≠ 0:** IDLE→DIV. The block captures |rs| and |rt| (signed) or raw values (unsigned) and records the quotient and remainder signs. The iteration counter is cleared.
  - Each DIV cycle runs one restoring step: shift the {rem, quo} pair left by one, trial-subtract the divisor, and set the quotient LSB on a non-negative result.
  - After 32 steps, the block moves DIV→FIX.
  - In FIX, signed ops negate the quotient if the operand signs differ, and the remainder takes the dividend's sign. LO is loaded with the quotient and HI with the remainder; `whi`=`wlo`=1; state returns to IDLE.
- **Divide by zero (rt=0, signed or unsigned):** IDLE→FIX directly with no sign fix. Result: HI=`rs_data`, LO=0xFFFFFFFF.
- **Signed overflow (0x80000000 / 0xFFFFFFFF):** result is LO=0x80000000, HI=0, which falls out of the magnitude datapath naturally.
- **Write pulses:** `whi`/`wlo` are high for exactly one cycle, then return to 0. `hi_wdata`/`lo_wdata` hold their last value.
- **`busy`** = (state ≠ IDLE), combinational from the state register.
- **Flush:**
  - A flush in MUL, DIV or FIX returns the block to IDLE at the next edge and suppresses the write; `whi`/`wlo` stay 0.
  - A flush in the cycle where `whi`/`wlo` are already high does not retract that write, which is committed.
  - A flush coinciding with `op_valid` in IDLE blocks acceptance.
- **Reset mid-operation:** the block goes to IDLE immediately (asynchronously), all outputs drop to 0, and the operation is lost.

## Timing
- Accept cycle = T.
- **MTHI/MTLO:** write pulse in T+1; `busy` never asserts.
- **MULT/MULTU:** `busy` in T+1; write pulse in T+2.
- **DIV/DIVU:** `busy` in T+1..T+33 (32 DIV cycles plus FIX); write pulse in T+34.
- **Divide by zero:** `busy` in T+1 (FIX); write pulse in T+2.
- A new operation may be accepted in the same cycle the previous write pulse is high, since state is already IDLE.
- HI/LO readers see the new value in the pulse cycle through the HI/LO register's write bypass.

## Test plan
- **Reset:** assert `rst_n`=0 mid-DIV (at T+5) → `busy`, `whi` and `wlo` go to 0 immediately and no write occurs after release.
- **MULT:** MULT rs=0xFFFFFFFE, rt=0x00000003 at T → `busy`=1 only in T+1; in T+2 `whi`=`wlo`=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **DIVU:** DIVU rs=100, rt=7 → `busy` high T+1..T+33; in T+34 LO=14, HI=2.
- **Signed DIV:**
  - DIV rs=0xFFFFFFF9 (−7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** DIV rs=5, rt=0 → write in T+2 with HI=5, LO=0xFFFFFFFF.
- **Flush and back-to-back issue:**
  - `flush`=1 at T+10 of DIVU → no write pulse; `busy`=0 in T+11.
  - MTLO rs=0x1234 accepted at T+11 → `wlo`=1 with LO=0x1234 in T+12.
  - `op_valid` presented during `busy` → ignored, with no write.

Source files
------------

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns every
// write into the HI/LO register pair. Multiplies take one busy cycle.
// Divides run a 32-step restoring loop on magnitudes, then fix the signs.
module hilo_mdu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic        whi,
  output logic        wlo,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state, state_n;
  logic [31:0] opa, opb;
  logic [31:0] rem, quo;
  logic [4:0]  cnt;
  logic        mul_signed, neg_q, neg_r;

  logic        accept, div_signed;
  logic [63:0] ext_a, ext_b, product;
  logic [32:0] trial;
  logic [31:0] q_fix, r_fix;
  logic        whi_n, wlo_n;
  logic [31:0] hi_n, lo_n;

  assign accept     = (state == IDLE) && op_valid && !flush;
  assign div_signed = (op == OP_DIV);
  assign busy       = (state != IDLE);

  // Multiply operands widened to 64 bits so one product serves both signednesses.
  assign ext_a   = mul_signed ? {{32{opa[31]}}, opa} : {32'd0, opa};
  assign ext_b   = mul_signed ? {{32{opb[31]}}, opb} : {32'd0, opb};
  assign product = ext_a * ext_b;

  // Restoring step: shift the next dividend bit into rem and try the divisor.
  assign trial = {rem, quo[31]} - {1'b0, opb};

  // Sign fix applied only in FIX; divide-by-zero loads flags cleared.
  assign q_fix = neg_q ? (32'd0 - quo) : quo;
  assign r_fix = neg_r ? (32'd0 - rem) : rem;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and next HI/LO write values; a flush kills any pending write.
  always_comb begin
    state_n = state;
    whi_n   = 1'b0;
    wlo_n   = 1'b0;
    hi_n    = hi_wdata;
    lo_n    = lo_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: state_n = MUL;
            OP_DIV, OP_DIVU:   state_n = (rt_data == 32'd0) ? FIX : DIV;
            OP_MTHI: begin
              whi_n = 1'b1;
              hi_n  = rs_data;
            end
            OP_MTLO: begin
              wlo_n = 1'b1;
              lo_n  = rs_data;
            end
            default: state_n = IDLE;
          endcase
        end
      end
      MUL: begin
        state_n = IDLE;
        if (!flush) begin
          whi_n = 1'b1;
          wlo_n = 1'b1;
          hi_n  = product[63:32];
          lo_n  = product[31:0];
        end
      end
      DIV: begin
        if (flush)              state_n = IDLE;
        else if (cnt == 5'd31)  state_n = FIX;
      end
      FIX: begin
        state_n = IDLE;
        if (!flush) begin
          whi_n = 1'b1;
          wlo_n = 1'b1;
          hi_n  = r_fix;
          lo_n  = q_fix;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture on accept and one restoring divide step per DIV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa        <= 32'd0;
      opb        <= 32'd0;
      rem        <= 32'd0;
      quo        <= 32'd0;
      cnt        <= 5'd0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else if (accept) begin
      cnt <= 5'd0;
      case (op)
        OP_MULT, OP_MULTU: begin
          opa        <= rs_data;
          opb        <= rt_data;
          mul_signed <= (op == OP_MULT);
        end
        OP_DIV, OP_DIVU: begin
          if (rt_data == 32'd0) begin
            rem   <= rs_data;
            quo   <= 32'hFFFF_FFFF;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else begin
            rem   <= 32'd0;
            quo   <= (div_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
            opb   <= (div_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
            neg_q <= div_signed && (rs_data[31] ^ rt_data[31]);
            neg_r <= div_signed && rs_data[31];
          end
        end
        default: cnt <= 5'd0;
      endcase
    end else if (state == DIV) begin
      cnt <= cnt + 5'd1;
      if (!trial[32]) begin
        rem <= trial[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= {rem[30:0], quo[31]};
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  // Registered write port: pulses last one cycle, data holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      whi      <= 1'b0;
      wlo      <= 1'b0;
      hi_wdata <= 32'd0;
      lo_wdata <= 32'd0;
    end else begin
      whi      <= whi_n;
      wlo      <= wlo_n;
      hi_wdata <= hi_n;
      lo_wdata <= lo_n;
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: directed and random stimulus against a latency/arithmetic
// reference model of the HI/LO sequencer.
module tb_hilo_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        flush = 1'b0;
  logic        busy, whi, wlo;
  logic [31:0] hi_wdata, lo_wdata;

  int checks = 0;
  int failures = 0;

  hilo_mdu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .busy(busy), .whi(whi), .wlo(wlo),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo} for a nonzero-divisor op.
  function automatic logic [63:0] refResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin q = sa * sb; qv = q; return qv; end
      3'd1: return ua * ub;
      3'd2: begin q = sa / sb; r = sa % sb; qv = q; rv = r; return {rv[31:0], qv[31:0]}; end
      default: begin qv = ua / ub; rv = ua % ub; return {rv[31:0], qv[31:0]}; end
    endcase
  endfunction

  // Model: m_left counts remaining busy cycles; the edge that empties it writes.
  int          m_left = 0;
  logic        m_whi = 1'b0, m_wlo = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic [63:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_whi = 1'b0; m_wlo = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    end else begin
      m_whi = 1'b0;
      m_wlo = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_whi = 1'b1; m_wlo = 1'b1; m_hi = p_hi; m_lo = p_lo;
          end
        end
      end else if (op_valid && !flush) begin
        case (op)
          3'd0, 3'd1: begin
            m_res = refResult(op, rs_data, rt_data);
            p_hi = m_res[63:32]; p_lo = m_res[31:0]; m_left = 1;
          end
          3'd2, 3'd3: begin
            if (rt_data == 32'd0) begin
              p_hi = rs_data; p_lo = 32'hFFFF_FFFF; m_left = 1;
            end else begin
              m_res = refResult(op, rs_data, rt_data);
              p_hi = m_res[63:32]; p_lo = m_res[31:0]; m_left = 33;
            end
          end
          3'd4: begin m_whi = 1'b1; m_hi = rs_data; end
          3'd5: begin m_wlo = 1'b1; m_lo = rs_data; end
          default: m_left = 0;
        endcase
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    checkOutput("busy", 32'(busy), 32'(m_left > 0));
    checkOutput("whi", 32'(whi), 32'(m_whi));
    checkOutput("wlo", 32'(wlo), 32'(m_wlo));
    checkOutput("hi_wdata", hi_wdata, m_hi);
    checkOutput("lo_wdata", lo_wdata, m_lo);
  end

  // Present one op for one cycle, starting at a negedge; returns at the next negedge.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Wait (bounded) for the write pulse and check its latency, enables and data.
  task automatic waitPulse(input string name, input int expLat, input logic [1:0] ew,
                           input logic [31:0] eh, input logic [31:0] el);
    int  n = 1;
    bit  seen = 0;
    while (n <= 60 && !seen) begin
      if (whi || wlo) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_pulse required=pulse", name);
    end else begin
      checkOutput({name, "_lat"}, 32'(n), 32'(expLat));
      checkOutput({name, "_we"}, 32'({whi, wlo}), 32'(ew));
      if (ew[1]) checkOutput({name, "_hi"}, hi_wdata, eh);
      if (ew[0]) checkOutput({name, "_lo"}, lo_wdata, el);
    end
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int writes;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_we", 32'({whi, wlo}), 32'd0);
    checkOutput("reset_hi", hi_wdata, 32'd0);
    checkOutput("reset_lo", lo_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    checkOutput("mult_busy_t1", 32'(busy), 32'd1);
    waitPulse("mult", 2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    checkOutput("mult_busy_t2", 32'(busy), 32'd0);
    applyStimulus(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    waitPulse("multu", 2, 2'b11, 32'h0000_0002, 32'hFFFF_FFFA);
    applyStimulus(3'd3, 32'd100, 32'd7);
    waitPulse("divu", 34, 2'b11, 32'd2, 32'd14);
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
    waitPulse("div_neg", 34, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    waitPulse("div_ovf", 34, 2'b11, 32'd0, 32'h8000_0000);
    applyStimulus(3'd2, 32'd5, 32'd0);
    waitPulse("div_zero", 2, 2'b11, 32'd5, 32'hFFFF_FFFF);

    // Flush at T+10 of a DIVU, then MTLO issued at T+11.
    applyStimulus(3'd3, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_we", 32'({whi, wlo}), 32'd0);
    applyStimulus(3'd5, 32'h0000_1234, 32'd0);
    waitPulse("mtlo", 1, 2'b01, 32'd0, 32'h0000_1234);

    // op_valid while busy is dropped.
    applyStimulus(3'd3, 32'd50, 32'd5);
    op_valid = 1'b1; op = 3'd4; rs_data = 32'hDEAD_BEEF;
    repeat (5) @(negedge clk);
    op_valid = 1'b0;
    waitPulse("ignored_op", 29, 2'b11, 32'd0, 32'd10);

    // Reset at T+5 of a DIVU.
    applyStimulus(3'd3, 32'd12345, 32'd6);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_we", 32'({whi, wlo}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    writes = 0;
    repeat (40) begin
      @(negedge clk);
      if (whi || wlo) writes++;
    end
    checkOutput("rst_no_write", 32'(writes), 32'd0);

    // Random traffic, including flushes and divide-by-zero.
    repeat (2500) begin
      op_valid = 1'($urandom_range(0, 1));
      op       = 3'($urandom_range(0, 7));
      rs_data  = pickVal();
      rt_data  = pickVal();
      flush    = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    op_valid = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
